// File: rtl/matr_ctrl.sv
// ---------------------------------------------------------------------------
// matr_ctrl -- multi-cycle controller for the "matr" instruction.
//
// Computes C = A x B for row-major N x N matrices of DW-bit words held in
// data memory (element stride 4 bytes). It does this by sequencing one
// memory access per cycle through the shared data-memory port, and it
// stalls the pipeline until the whole of C has been written.
//
// Parameters
//   N          matrix dimension (2..15)
//   DW         data / address width
//
// Ports
//   clk_50     clock; every state change happens on its rising edge
//   rst_n      synchronous active-low reset
//   START      decoded matr instruction valid in EX (only seen in IDLE)
//   BASE_A     byte address of A[0][0]
//   BASE_B     byte address of B[0][0]
//   BASE_C     byte address of C[0][0]
//   MEM_ADDR   data memory byte address (word aligned, 0 when idle)
//   MEM_RD     read strobe; data is returned on MEM_RDATA one cycle later
//   MEM_WR     write strobe; the write happens in the same cycle
//   MEM_WDATA  write data (0 when not writing)
//   MEM_RDATA  registered read data from data memory
//   STALL      holds PC, IF/ID and ID/EX while high
//   DONE       one-cycle pulse once C is complete
//
// Each product term takes four cycles (RD_A, RD_B, CAP_B, MAC) and each
// element one extra cycle (WR), so an element costs 4N+1 cycles.
// ---------------------------------------------------------------------------
module matr_ctrl #(
    parameter int N  = 3,
    parameter int DW = 32
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          START,
    input  logic [DW-1:0] BASE_A,
    input  logic [DW-1:0] BASE_B,
    input  logic [DW-1:0] BASE_C,
    output logic [DW-1:0] MEM_ADDR,
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          STALL,
    output logic          DONE
);

    localparam int IW = 4;  // enough for indices up to 14

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_B  = 3'd2;
    localparam logic [2:0] S_CAP_B = 3'd3;
    localparam logic [2:0] S_MAC   = 3'd4;
    localparam logic [2:0] S_WR    = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [DW-1:0] N_W        = DW'(N);
    // Clears the two byte-offset bits so every access is word aligned,
    // even if a base register carries a misaligned value.
    localparam logic [DW-1:0] ALIGN_MASK = ~DW'(3);

    logic [2:0]    state_reg, state_next;
    logic [IW-1:0] i_reg, j_reg, k_reg;
    logic [DW-1:0] acc_reg, a_reg, b_reg;
    logic [DW-1:0] base_a_reg, base_b_reg, base_c_reg;

    // Flat element indices and byte addresses; all sums wrap modulo 2^DW.
    logic [DW-1:0] i_ext, j_ext, k_ext;
    logic [DW-1:0] addr_a, addr_b, addr_c;
    logic [DW-1:0] prod;

    assign i_ext  = DW'(i_reg);
    assign j_ext  = DW'(j_reg);
    assign k_ext  = DW'(k_reg);
    assign addr_a = (base_a_reg + ((N_W * i_ext + k_ext) << 2)) & ALIGN_MASK;
    assign addr_b = (base_b_reg + ((N_W * k_ext + j_ext) << 2)) & ALIGN_MASK;
    assign addr_c = (base_c_reg + ((N_W * i_ext + j_ext) << 2)) & ALIGN_MASK;

    // Only the low DW bits of the product matter: two's-complement signed
    // and unsigned multiplication agree there, and the accumulator wraps.
    assign prod = a_reg * b_reg;

    // Next-state logic and memory-port / handshake outputs.
    always_comb begin
        state_next = state_reg;
        MEM_ADDR   = '0;
        MEM_RD     = 1'b0;
        MEM_WR     = 1'b0;
        MEM_WDATA  = '0;
        STALL      = 1'b0;
        DONE       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Stall in the same cycle the instruction is seen so the
                // pipeline holds matr in EX while the run proceeds.
                if (START) begin
                    STALL      = 1'b1;
                    state_next = S_RD_A;
                end
            end
            S_RD_A: begin
                STALL      = 1'b1;
                MEM_RD     = 1'b1;
                MEM_ADDR   = addr_a;
                state_next = S_RD_B;
            end
            S_RD_B: begin
                STALL      = 1'b1;
                MEM_RD     = 1'b1;
                MEM_ADDR   = addr_b;
                state_next = S_CAP_B;
            end
            S_CAP_B: begin
                STALL      = 1'b1;
                state_next = S_MAC;
            end
            S_MAC: begin
                STALL      = 1'b1;
                state_next = (k_reg == LAST_IDX) ? S_WR : S_RD_A;
            end
            S_WR: begin
                STALL      = 1'b1;
                MEM_WR     = 1'b1;
                MEM_ADDR   = addr_c;
                MEM_WDATA  = acc_reg;
                state_next = (i_reg == LAST_IDX && j_reg == LAST_IDX) ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                // STALL stays low so the pipeline moves past matr now.
                DONE       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, index counters, operand capture and accumulator.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            base_a_reg <= '0;
            base_b_reg <= '0;
            base_c_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        base_a_reg <= BASE_A;
                        base_b_reg <= BASE_B;
                        base_c_reg <= BASE_C;
                        i_reg      <= '0;
                        j_reg      <= '0;
                        k_reg      <= '0;
                        acc_reg    <= '0;
                    end
                end
                // The A read issued in RD_A returns during RD_B, and the B
                // read issued in RD_B returns during CAP_B.
                S_RD_B:  a_reg <= MEM_RDATA;
                S_CAP_B: b_reg <= MEM_RDATA;
                S_MAC: begin
                    acc_reg <= acc_reg + prod;
                    if (k_reg != LAST_IDX) begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_WR: begin
                    k_reg   <= '0;
                    acc_reg <= '0;
                    if (j_reg == LAST_IDX) begin
                        j_reg <= '0;
                        i_reg <= i_reg + 1'b1;
                    end else begin
                        j_reg <= j_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matr_ctrl -- self-checking bench for matr_ctrl (N=3, DW=32).
//
// A table of matrix vectors (bases, A, B, expected C) is run one after the
// other. During every run each cycle's outputs are compared against the
// access schedule derived from the element/term timing (4 cycles per term,
// 1 write cycle per element, DONE at T+118), and C is read back from the
// memory model afterwards. Extra sequences cover START held high for the
// whole run and a reset asserted mid-operation.
// ---------------------------------------------------------------------------
module tb_matr_ctrl;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

    logic          clk_50 = 1'b0;
    logic          rst_n;
    logic          START;
    logic [DW-1:0] BASE_A, BASE_B, BASE_C;
    logic [DW-1:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic          MEM_RD, MEM_WR, STALL, DONE;

    always #5 clk_50 = ~clk_50;

    matr_ctrl #(.N(N), .DW(DW)) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .START     (START),
        .BASE_A    (BASE_A),
        .BASE_B    (BASE_B),
        .BASE_C    (BASE_C),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_RD    (MEM_RD),
        .MEM_WR    (MEM_WR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .STALL     (STALL),
        .DONE      (DONE)
    );

    // 256-word data memory with registered read; the bench loads it
    // through a side port so the array has a single writer.
    logic [31:0] mem [256];
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;

    always @(posedge clk_50) begin
        if (ld_en)  mem[ld_addr[9:2]]  <= ld_data;
        if (MEM_WR) mem[MEM_ADDR[9:2]] <= MEM_WDATA;
        if (MEM_RD) MEM_RDATA <= mem[MEM_ADDR[9:2]];
    end

    typedef struct packed {
        logic [31:0]      ba;
        logic [31:0]      bb;
        logic [31:0]      bc;
        logic [0:8][31:0] a;
        logic [0:8][31:0] b;
        logic [0:8][31:0] c;
    } vec_t;

    vec_t vecs [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic done_prev = 1'b0;

    // Advance to the next negedge and apply the every-cycle protocol rules.
    task automatic step();
        @(negedge clk_50);
        cyc++;
        total++;
        if ((MEM_RD && MEM_WR) || (MEM_ADDR[1:0] != 2'b00) || (DONE && done_prev)) begin
            bad++;
            $display("FAIL protocol cyc=%0d rd=%b wr=%b addr=%h done=%b done_prev=%b required rd&wr=0 addr[1:0]=0 single-cycle done",
                     cyc, MEM_RD, MEM_WR, MEM_ADDR, DONE, done_prev);
        end
        done_prev = DONE;
    endtask

    task automatic ld_word(input logic [31:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic check_outs(input string name, input int rel,
                              input logic e_stall, input logic e_done,
                              input logic e_rd, input logic e_wr,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata);
        total++;
        if ({STALL, DONE, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA} !==
            {e_stall, e_done, e_rd, e_wr, e_addr, e_wdata}) begin
            bad++;
            $display("FAIL %s rel=%0d got stall=%b done=%b rd=%b wr=%b addr=%h wdata=%h required stall=%b done=%b rd=%b wr=%b addr=%h wdata=%h",
                     name, rel, STALL, DONE, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA,
                     e_stall, e_done, e_rd, e_wr, e_addr, e_wdata);
        end
    endtask

    // One matr run. hold: keep START high throughout (expect a second run to
    // begin at T+119). rst_at: relative cycle in which rst_n is held low for
    // one cycle (0 = never).
    task automatic run(input int v, input bit hold, input int rst_at);
        vec_t t;
        int   last_rel;
        int   bad_before;
        t = vecs[v];
        bad_before = bad;
        for (int n = 0; n < 9; n++) ld_word(t.ba + 32'(4 * n), t.a[n]);
        for (int n = 0; n < 9; n++) ld_word(t.bb + 32'(4 * n), t.b[n]);
        for (int n = 0; n < 9; n++) ld_word(t.bc + 32'(4 * n), SENTINEL);

        BASE_A = t.ba;
        BASE_B = t.bb;
        BASE_C = t.bc;
        START  = 1'b1;
        #1;
        check_outs("start_cycle", 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        last_rel = hold ? 120 : 125;
        for (int rel = 1; rel <= last_rel; rel++) begin
            logic        e_stall, e_done, e_rd, e_wr;
            logic [31:0] e_addr, e_wdata;
            step();
            if (!hold) START = 1'b0;
            e_stall = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            e_addr  = 32'h0; e_wdata = 32'h0;
            if (!(rst_at > 0 && rel > rst_at)) begin
                if (rel <= 117) begin
                    int e, p, ii, jj, kk;
                    e  = (rel - 1) / 13;
                    p  = (rel - 1) % 13;
                    ii = e / 3;
                    jj = e % 3;
                    kk = p / 4;
                    e_stall = 1'b1;
                    if (p == 12) begin
                        e_wr    = 1'b1;
                        e_addr  = t.bc + 32'(4 * (3 * ii + jj));
                        e_wdata = t.c[e];
                    end else if (p % 4 == 0) begin
                        e_rd   = 1'b1;
                        e_addr = t.ba + 32'(4 * (3 * ii + kk));
                    end else if (p % 4 == 1) begin
                        e_rd   = 1'b1;
                        e_addr = t.bb + 32'(4 * (3 * kk + jj));
                    end
                end else if (rel == 118) begin
                    e_done = 1'b1;
                end else if (hold && rel == 119) begin
                    e_stall = 1'b1;
                end else if (hold && rel == 120) begin
                    e_stall = 1'b1;
                    e_rd    = 1'b1;
                    e_addr  = t.ba;
                end
            end
            check_outs("cycle", rel, e_stall, e_done, e_rd, e_wr, e_addr, e_wdata);
            rst_n = (rel == rst_at) ? 1'b0 : 1'b1;
        end

        if (hold) begin
            // Abort the second run that START-held-high launched.
            START = 1'b0;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
        end

        for (int n = 0; n < 9; n++) begin
            logic [31:0] got, want;
            got  = mem[(t.bc + 32'(4 * n)) >> 2 & 32'hFF];
            want = (rst_at > 0 && n > 0) ? SENTINEL : t.c[n];
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL c_elem v=%0d n=%0d got=%h required=%h", v, n, got, want);
            end
        end
        $display("run v=%0d hold=%0d rst_at=%0d base_a=%h base_b=%h base_c=%h new_bad=%0d",
                 v, hold, rst_at, t.ba, t.bb, t.bc, bad - bad_before);
    endtask

    initial begin
        rst_n  = 1'b0;
        START  = 1'b0;
        BASE_A = '0;
        BASE_B = '0;
        BASE_C = '0;
        ld_en  = 1'b0;
        ld_addr = '0;
        ld_data = '0;

        // v0: identity, A=1..9 at 0, B=I at 36, C at 72.
        vecs[0].ba = 32'd0; vecs[0].bb = 32'd36; vecs[0].bc = 32'd72;
        for (int n = 0; n < 9; n++) begin
            vecs[0].a[n] = 32'(n + 1);
            vecs[0].b[n] = (n % 4 == 0) ? 32'd1 : 32'd0;
            vecs[0].c[n] = 32'(n + 1);
        end
        // v1: A=1..9, B=9..1; C base wraps past 2^32 back to address 0.
        vecs[1].ba = 32'h0000_0100; vecs[1].bb = 32'h0000_0124; vecs[1].bc = 32'hFFFF_FFF0;
        for (int n = 0; n < 9; n++) begin
            vecs[1].a[n] = 32'(n + 1);
            vecs[1].b[n] = 32'(9 - n);
        end
        vecs[1].c = {32'd30, 32'd24, 32'd18, 32'd84, 32'd69, 32'd54, 32'd138, 32'd114, 32'd90};
        // v2: product wrap, 0x10000 * 0x10000 = 2^32 -> 0.
        vecs[2].ba = 32'd0; vecs[2].bb = 32'd36; vecs[2].bc = 32'd72;
        for (int n = 0; n < 9; n++) begin
            vecs[2].a[n] = 32'h0001_0000;
            vecs[2].b[n] = 32'h0001_0000;
            vecs[2].c[n] = 32'h0000_0000;
        end
        // v3: signed, (-1)*2 summed three times = -6.
        vecs[3].ba = 32'd0; vecs[3].bb = 32'd36; vecs[3].bc = 32'd72;
        for (int n = 0; n < 9; n++) begin
            vecs[3].a[n] = 32'hFFFF_FFFF;
            vecs[3].b[n] = 32'd2;
            vecs[3].c[n] = 32'hFFFF_FFFA;
        end

        // Reset state.
        repeat (3) step();
        check_outs("reset_held", 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step();
        check_outs("idle_after_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        for (int v = 0; v < 4; v++) run(v, 1'b0, 0);
        run(0, 1'b1, 0);   // START held high the whole time
        run(1, 1'b0, 20);  // reset during cycle T+20

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matr_ctrl.md
MATR_CTRL -- requirements
Module: matr_ctrl

Interface
REQ-001 The block SHALL take parameter N, default 3: matrix dimension, legal range 2..15.
REQ-002 The block SHALL take parameter DW, default 32: data and address width.
REQ-003 The block SHALL have port clk_50, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port START, input, 1: decoded matr instruction valid in EX.
REQ-006 The block SHALL have port BASE_A, input, DW: address of A[0][0] (rs1 value).
REQ-007 The block SHALL have port BASE_B, input, DW: address of B[0][0] (rs2 value).
REQ-008 The block SHALL have port BASE_C, input, DW: address of C[0][0] (rd value).
REQ-009 The block SHALL have port MEM_ADDR, output, DW: data memory byte address.
REQ-010 The block SHALL have port MEM_RD, output, 1: read strobe; data appears on MEM_RDATA in the next cycle.
REQ-011 The block SHALL have port MEM_WR, output, 1: write strobe; write occurs in the same cycle.
REQ-012 The block SHALL have port MEM_WDATA, output, DW: write data.
REQ-013 The block SHALL have port MEM_RDATA, input, DW: registered read data from data memory.
REQ-014 The block SHALL have port STALL, output, 1: holds the pipeline (PC, IF/ID, ID/EX) while high.
REQ-015 The block SHALL have port DONE, output, 1: one-cycle pulse when C is complete.

Function
REQ-016 The block SHALL compute C = A x B for row-major N x N signed DW-bit word matrices, with element stride 4 bytes.
REQ-017 The block SHALL implement states IDLE, RD_A, RD_B, CAP_B, MAC, WR and FIN.
REQ-018 IDLE: when START=1, the block SHALL latch the three bases, clear i, j, k and acc, and go to RD_A; otherwise it SHALL stay in IDLE.
REQ-019 RD_A: the block SHALL drive MEM_RD=1 and MEM_ADDR=BASE_A+4*(N*i+k), then go to RD_B.
REQ-020 RD_B: the block SHALL drive MEM_RD=1 and MEM_ADDR=BASE_B+4*(N*k+j), latch MEM_RDATA into a_reg, then go to CAP_B.
REQ-021 CAP_B: the block SHALL latch MEM_RDATA into b_reg, then go to MAC.
REQ-022 MAC: the block SHALL set acc = acc + a_reg*b_reg, keeping the low DW bits with wrap and no saturation; if k=N-1 it SHALL go to WR, else k++ and go to RD_A.
REQ-023 WR: the block SHALL drive MEM_WR=1, MEM_ADDR=BASE_C+4*(N*i+j) and MEM_WDATA=acc, then clear k and acc and advance j, or wrap j to 0 and increment i.
REQ-024 After the write of element (N-1,N-1), WR SHALL go to FIN; otherwise it SHALL go to RD_A.
REQ-025 FIN: the block SHALL drive DONE=1 for exactly one cycle, then go to IDLE.
REQ-026 Elements SHALL be produced in row-major order (i outer, j inner).
REQ-027 If C overlaps A or B, later reads SHALL return already-written C values; the block SHALL NOT add hazard protection.
REQ-028 All address arithmetic SHALL wrap modulo 2^DW.
REQ-029 MEM_ADDR[1:0] SHALL always be driven 00.
REQ-030 MEM_ADDR and MEM_WDATA SHALL be 0 in states that issue no access.
REQ-031 MEM_RD and MEM_WR SHALL never be high in the same cycle.
REQ-032 STALL SHALL be high combinationally when START=1 in IDLE, and high in RD_A, RD_B, CAP_B, MAC and WR.
REQ-033 STALL SHALL be low in FIN and in IDLE without START, so the pipeline advances past matr on the DONE cycle.
REQ-034 START SHALL be ignored in every state other than IDLE, including FIN.
REQ-035 Latency: with START sampled in IDLE at cycle T, the first MEM_RD SHALL occur at T+1.
REQ-036 Latency: the first MEM_WR SHALL occur at T+4N+1.
REQ-037 Latency: the DONE pulse SHALL occur at T+N*N*(4N+1)+1, which is T+118 for N=3.

Reset
REQ-038 While rst_n=0 at a clock edge, the state SHALL become IDLE and i, j, k, acc, a_reg, b_reg and the latched bases SHALL become 0.
REQ-039 After reset, STALL, DONE, MEM_RD, MEM_WR, MEM_ADDR and MEM_WDATA SHALL all be 0.
REQ-040 Reset asserted mid-operation SHALL abort the operation, with no further memory access and no DONE; already-written C elements SHALL remain as written.

Verification
REQ-041 Identity: A=1..9 at 0, B=identity at 36, C base 72, START at T -> C=1..9 at 72..104, DONE only at T+118, STALL high T..T+117.
REQ-042 General: A=1..9, B=9..1 -> C = 30,24,18,84,69,54,138,114,90; writes at T+13+13n for n=0..8.
REQ-043 Wrap/sign: every A element 0x00010000 and every B element 0x00010000 -> every C element 0. Every A element 0xFFFFFFFF and every B element 2 -> every C element 0xFFFFFFFA.
REQ-044 Busy START: START held high through the whole operation -> exactly one run and one DONE. A new run starts only when START=1 in IDLE, which is T+119 at the earliest.
REQ-045 Mid reset: rst_n=0 at T+20 for one cycle -> from T+21 STALL=0 and no MEM_RD/MEM_WR, only C[0][0] written, DONE never pulses.
REQ-046 Protocol check every cycle: MEM_RD and MEM_WR never both high, MEM_ADDR[1:0]=00, DONE at most one cycle wide.
